// File: rtl/multi_output_ctrl_if.sv
// Bundle between the compare/watchdog source and multi_output_ctrl.
// The master drives verdicts, kicks and references; the slave returns drive and status.
interface multi_output_ctrl_if #(
    parameter int NCH = 2
);
    logic           valid1;
    logic           valid2;
    logic           pass1;
    logic           pass2;
    logic           data_ready;
    logic [NCH-1:0] order;
    logic           ref_a;
    logic           ref_b;
    logic [NCH-1:0] relay_ctrl;
    logic [NCH-1:0] switch_ctrl;
    logic [1:0]     state;
    logic [1:0]     out_status;
    logic [3:0]     err_cnt;
    logic           timeout;

    modport master (
        output valid1, valid2, pass1, pass2, data_ready,
        output order, ref_a, ref_b,
        input  relay_ctrl, switch_ctrl, state,
        input  out_status, err_cnt, timeout
    );

    modport slave (
        input  valid1, valid2, pass1, pass2, data_ready,
        input  order, ref_a, ref_b,
        output relay_ctrl, switch_ctrl, state,
        output out_status, err_cnt, timeout
    );
endinterface

// File: rtl/multi_output_ctrl.sv
// Verdict controller with error/watchdog lock and per-channel relay/switch drive.
// Optional err_cnt decay after 256 passes: define MULTI_OUTPUT_CTRL_ERR_DECAY_EN.
module multi_output_ctrl #(
    parameter int NCH       = 2,
    parameter int ERR_LIMIT = 3,
    parameter int TIMEOUT   = 2500000,
    parameter int CNT_W     = 24
) (
    input  logic               clk1,
    input  logic               rst,
    multi_output_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2,
        LOCK  = 2'd3
    } state_t;

    state_t           st;
    logic [1:0]       status_q;
    logic [3:0]       err_q;
    logic             to_q;
    logic [CNT_W-1:0] wd_cnt;
    logic [NCH-1:0]   relay_q;
    logic [NCH-1:0]   switch_q;

    logic       pass_evt;
    logic       fail_evt;
    logic       expire;
    logic       lock_hit;
    logic       decay;
    logic [3:0] err_inc;
    logic [3:0] err_dec;

    assign pass_evt = bus.valid1 & bus.valid2 & bus.pass1 & bus.pass2;
    assign fail_evt = (bus.valid1 | bus.valid2) & ~pass_evt;
    assign expire   = (st == RUN) && !bus.data_ready
                   && (wd_cnt == CNT_W'(TIMEOUT - 1));
    assign err_inc  = (err_q == 4'hF) ? err_q : err_q + 4'd1;
    assign err_dec  = (err_q == 4'h0) ? err_q : err_q - 4'd1;
    assign lock_hit = (err_inc >= 4'(ERR_LIMIT));

`ifdef MULTI_OUTPUT_CTRL_ERR_DECAY_EN
    // Run of consecutive accepted passes; the 256th pays back one error.
    logic [7:0] pass_run;
    logic       active;

    assign active = (st == IDLE) || (st == RUN);
    assign decay  = pass_evt && active && (pass_run == 8'hFF);

    always_ff @(posedge clk1) begin
        if (rst || (fail_evt && active)) begin
            pass_run <= '0;
        end else if (pass_evt && active) begin
            pass_run <= pass_run + 8'd1;
        end
    end
`else
    assign decay = 1'b0;
`endif

    always_ff @(posedge clk1) begin
        if (rst) begin
            st       <= IDLE;
            status_q <= 2'b11;
            err_q    <= '0;
            to_q     <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    wd_cnt <= '0;
                    if (pass_evt) begin
                        st       <= RUN;
                        status_q <= 2'b00;
                        if (decay) err_q <= err_dec;
                    end else if (fail_evt) begin
                        st       <= lock_hit ? LOCK : ERROR;
                        status_q <= 2'b01;
                        err_q    <= err_inc;
                    end
                end
                RUN: begin
                    if (fail_evt) begin
                        st       <= (lock_hit || expire) ? LOCK : ERROR;
                        status_q <= 2'b01;
                        err_q    <= err_inc;
                    end else begin
                        if (pass_evt) begin
                            status_q <= 2'b00;
                            if (decay) err_q <= err_dec;
                        end
                        if (expire) st <= LOCK;
                    end
                    if (expire) to_q <= 1'b1;
                    // Leaving RUN clears the count so it rests at 0 elsewhere.
                    if (bus.data_ready || fail_evt || expire) begin
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                ERROR: st <= IDLE;
                LOCK:  st <= LOCK;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (rst || st != RUN) begin
            relay_q  <= '1;
            switch_q <= ~bus.order;
        end else begin
            relay_q  <= {NCH{bus.ref_a}} ^ bus.order;
            switch_q <= {NCH{bus.ref_b}} ^ bus.order;
        end
    end

    assign bus.state       = st;
    assign bus.out_status  = status_q;
    assign bus.err_cnt     = err_q;
    assign bus.timeout     = to_q;
    assign bus.relay_ctrl  = relay_q;
    assign bus.switch_ctrl = switch_q;

endmodule

// File: tb/tb_multi_output_ctrl.sv
// Scoreboard bench for multi_output_ctrl with NCH=2, ERR_LIMIT=3, TIMEOUT=16.
// Each step queues the expected post-edge outputs as it drives, then pops and compares.
module tb_multi_output_ctrl;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] ERR  = 2'd2;
    localparam logic [1:0] LOCK = 2'd3;

    // stimulus codes {rst, valid1, valid2, pass1, pass2, data_ready}
    localparam logic [5:0] N  = 6'b000000;
    localparam logic [5:0] R  = 6'b100000;
    localparam logic [5:0] RP = 6'b111110;
    localparam logic [5:0] P  = 6'b011110;
    localparam logic [5:0] PD = 6'b011111;
    localparam logic [5:0] F  = 6'b011100;
    localparam logic [5:0] D  = 6'b000001;
    localparam logic [5:0] V1 = 6'b010100;
    localparam logic [5:0] V2 = 6'b001010;

    typedef struct packed {
        logic [5:0] in;
        logic [1:0] st;
        logic [1:0] sts;
        logic [3:0] err;
        logic       to;
    } step_t;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] sts;
        logic [3:0] err;
        logic       to;
        logic [1:0] rly;
        logic [1:0] sw;
    } obs_t;

    logic       clk1 = 1'b0;
    logic       rst;
    int         vectors = 0;
    int         miscompares = 0;
    int         stepn = 0;
    logic [1:0] m_st = IDLE;
    obs_t       exp_q[$];

    multi_output_ctrl_if #(.NCH(2)) ifc ();

    multi_output_ctrl #(
        .NCH(2),
        .ERR_LIMIT(3),
        .TIMEOUT(16),
        .CNT_W(24)
    ) dut (
        .clk1(clk1),
        .rst(rst),
        .bus(ifc.slave)
    );

    always #5 clk1 = ~clk1;

    function automatic step_t S(input logic [5:0] in, input logic [1:0] st,
                                input logic [1:0] sts, input logic [3:0] err,
                                input logic to);
        return '{in: in, st: st, sts: sts, err: err, to: to};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%0d sts=%b err=%0d to=%b rly=%b sw=%b",
                         o.st, o.sts, o.err, o.to, o.rly, o.sw);
    endfunction

    function automatic obs_t sample();
        return {ifc.state, ifc.out_status, ifc.err_cnt, ifc.timeout,
                ifc.relay_ctrl, ifc.switch_ctrl};
    endfunction

    // Drive one cycle of stimulus and queue what must appear after the edge.
    task automatic apply(input step_t s);
        obs_t e;
        logic en;
        {rst, ifc.valid1, ifc.valid2, ifc.pass1, ifc.pass2, ifc.data_ready} = s.in;
        ifc.ref_a = stepn[0];
        ifc.ref_b = stepn[1];
        stepn++;
        en    = !s.in[5] && (m_st == RUN);
        e.st  = s.st;
        e.sts = s.sts;
        e.err = s.err;
        e.to  = s.to;
        for (int c = 0; c < 2; c++) begin
            if (en) begin
                e.rly[c] = ifc.order[c] ? ~ifc.ref_a : ifc.ref_a;
                e.sw[c]  = ifc.order[c] ? ~ifc.ref_b : ifc.ref_b;
            end else begin
                e.rly[c] = 1'b1;
                e.sw[c]  = ifc.order[c] ? 1'b0 : 1'b1;
            end
        end
        exp_q.push_back(e);
        m_st = s.st;
    endtask

    task automatic test_reset(input logic [1:0] ord);
        step_t t[$];
        obs_t g, e;
        ifc.order = ord;
        t.push_back(S(RP, IDLE, 2'b11, 4'd0, 1'b0));
        t.push_back(S(RP, IDLE, 2'b11, 4'd0, 1'b0));
        t.push_back(S(N,  IDLE, 2'b11, 4'd0, 1'b0));
        t.push_back(S(P,  RUN,  2'b00, 4'd0, 1'b0));
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk1); #1;
            g = sample();
            e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL reset[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_pass_run();
        step_t t[$];
        obs_t g, e;
        ifc.order = 2'b00;
        t.push_back(S(R, IDLE, 2'b11, 4'd0, 1'b0));
        t.push_back(S(P, RUN,  2'b00, 4'd0, 1'b0));
        repeat (6) t.push_back(S(N, RUN, 2'b00, 4'd0, 1'b0));
        t.push_back(S(P, RUN,  2'b00, 4'd0, 1'b0));
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk1); #1;
            g = sample();
            e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL pass_run[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_err_lock();
        step_t t[$];
        obs_t g, e;
        ifc.order = 2'b01;
        t.push_back(S(R, IDLE, 2'b11, 4'd0, 1'b0));
        t.push_back(S(P, RUN,  2'b00, 4'd0, 1'b0));
        t.push_back(S(F, ERR,  2'b01, 4'd1, 1'b0));
        t.push_back(S(N, IDLE, 2'b01, 4'd1, 1'b0));
        t.push_back(S(P, RUN,  2'b00, 4'd1, 1'b0));
        t.push_back(S(F, ERR,  2'b01, 4'd2, 1'b0));
        t.push_back(S(N, IDLE, 2'b01, 4'd2, 1'b0));
        t.push_back(S(P, RUN,  2'b00, 4'd2, 1'b0));
        t.push_back(S(F, LOCK, 2'b01, 4'd3, 1'b0));
        t.push_back(S(P, LOCK, 2'b01, 4'd3, 1'b0));
        t.push_back(S(P, LOCK, 2'b01, 4'd3, 1'b0));
        t.push_back(S(D, LOCK, 2'b01, 4'd3, 1'b0));
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk1); #1;
            g = sample();
            e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL err_lock[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_watchdog();
        step_t t[$];
        obs_t g, e;
        ifc.order = 2'b11;
        t.push_back(S(R, IDLE, 2'b11, 4'd0, 1'b0));
        t.push_back(S(P, RUN,  2'b00, 4'd0, 1'b0));
        repeat (15) t.push_back(S(N, RUN, 2'b00, 4'd0, 1'b0));
        t.push_back(S(N, LOCK, 2'b00, 4'd0, 1'b1));
        t.push_back(S(D, LOCK, 2'b00, 4'd0, 1'b1));
        t.push_back(S(R, IDLE, 2'b11, 4'd0, 1'b0));
        t.push_back(S(P, RUN,  2'b00, 4'd0, 1'b0));
        repeat (4) begin
            repeat (9) t.push_back(S(N, RUN, 2'b00, 4'd0, 1'b0));
            t.push_back(S(D, RUN, 2'b00, 4'd0, 1'b0));
        end
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk1); #1;
            g = sample();
            e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL watchdog[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_single_valid();
        step_t t[$];
        obs_t g, e;
        ifc.order = 2'b10;
        t.push_back(S(R,  IDLE, 2'b11, 4'd0, 1'b0));
        t.push_back(S(P,  RUN,  2'b00, 4'd0, 1'b0));
        t.push_back(S(N,  RUN,  2'b00, 4'd0, 1'b0));
        t.push_back(S(V1, ERR,  2'b01, 4'd1, 1'b0));
        t.push_back(S(F,  IDLE, 2'b01, 4'd1, 1'b0));
        t.push_back(S(N,  IDLE, 2'b01, 4'd1, 1'b0));
        t.push_back(S(P,  RUN,  2'b00, 4'd1, 1'b0));
        t.push_back(S(V2, ERR,  2'b01, 4'd2, 1'b0));
        t.push_back(S(N,  IDLE, 2'b01, 4'd2, 1'b0));
        t.push_back(S(F,  LOCK, 2'b01, 4'd3, 1'b0));
        t.push_back(S(N,  LOCK, 2'b01, 4'd3, 1'b0));
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk1); #1;
            g = sample();
            e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL single_valid[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_dr_expiry();
        step_t t[$];
        obs_t g, e;
        ifc.order = 2'b01;
        t.push_back(S(R, IDLE, 2'b11, 4'd0, 1'b0));
        t.push_back(S(P, RUN,  2'b00, 4'd0, 1'b0));
        repeat (15) t.push_back(S(N, RUN, 2'b00, 4'd0, 1'b0));
        t.push_back(S(D, RUN,  2'b00, 4'd0, 1'b0));
        repeat (15) t.push_back(S(N, RUN, 2'b00, 4'd0, 1'b0));
        t.push_back(S(N, LOCK, 2'b00, 4'd0, 1'b1));
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk1); #1;
            g = sample();
            e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL dr_expiry[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_fail_expiry();
        step_t t[$];
        obs_t g, e;
        ifc.order = 2'b00;
        t.push_back(S(R, IDLE, 2'b11, 4'd0, 1'b0));
        t.push_back(S(P, RUN,  2'b00, 4'd0, 1'b0));
        repeat (15) t.push_back(S(N, RUN, 2'b00, 4'd0, 1'b0));
        t.push_back(S(F, LOCK, 2'b01, 4'd1, 1'b1));
        t.push_back(S(P, LOCK, 2'b01, 4'd1, 1'b1));
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk1); #1;
            g = sample();
            e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL fail_expiry[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

`ifdef MULTI_OUTPUT_CTRL_ERR_DECAY_EN
    task automatic test_err_decay();
        step_t t[$];
        obs_t g, e;
        ifc.order = 2'b00;
        t.push_back(S(R, IDLE, 2'b11, 4'd0, 1'b0));
        t.push_back(S(P, RUN,  2'b00, 4'd0, 1'b0));
        t.push_back(S(F, ERR,  2'b01, 4'd1, 1'b0));
        t.push_back(S(N, IDLE, 2'b01, 4'd1, 1'b0));
        t.push_back(S(P, RUN,  2'b00, 4'd1, 1'b0));
        t.push_back(S(F, ERR,  2'b01, 4'd2, 1'b0));
        t.push_back(S(N, IDLE, 2'b01, 4'd2, 1'b0));
        for (int k = 1; k <= 256; k++) begin
            t.push_back(S(PD, RUN, 2'b00, (k == 256) ? 4'd1 : 4'd2, 1'b0));
        end
        t.push_back(S(D, RUN, 2'b00, 4'd1, 1'b0));
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk1); #1;
            g = sample();
            e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL err_decay[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask
`endif

    initial begin
        rst            = 1'b1;
        ifc.valid1     = 1'b0;
        ifc.valid2     = 1'b0;
        ifc.pass1      = 1'b0;
        ifc.pass2      = 1'b0;
        ifc.data_ready = 1'b0;
        ifc.order      = 2'b00;
        ifc.ref_a      = 1'b0;
        ifc.ref_b      = 1'b0;
        @(posedge clk1); #1;
        test_reset(2'b10);
        test_pass_run();
        test_err_lock();
        test_watchdog();
        test_single_valid();
        test_dr_expiry();
        test_fail_expiry();
`ifdef MULTI_OUTPUT_CTRL_ERR_DECAY_EN
        test_err_decay();
`endif
        test_fail_expiry();
        test_reset(2'b01);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
